mc_ctrl_sequencer: RTL and testbench
====================================

// Module: mc_ctrl_sequencer
// PURPOSE
//  State register and control-word generator for the multi-cycle MIPS core.
//  Takes the next-state proposal from the next-state logic, registers it and
//  drives every datapath control line. Also owns memory wait-state stalls,
//  illegal-opcode trapping and the one-cycle instruction-retire pulse.
// PARAMETERS
//  CNT_W  32  width of the performance counters (used only with MC_PERF_CNT_EN)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      reset; asynchronous, active-high
//  next_state   in   4      next-state proposal from the next-state logic
//  opcode       in   6      IR[31:26]
//  mem_ready    in   1      memory finished the current access
//  cur_state    out  4      registered state; fed back to the next-state logic
//  pc_write     out  1      unconditional PC write
//  pc_write_cond out 1      PC write if ALU zero (beq)
//  i_or_d       out  1      0 = PC addresses memory, 1 = ALUOut
//  mem_read     out  1      memory read request
//  mem_write    out  1      memory write request
//  ir_write     out  1      instruction register load
//  reg_dst      out  1      1 = rd, 0 = rt
//  mem_to_reg   out  1      1 = MDR, 0 = ALUOut
//  reg_write    out  1      register file write
//  alu_src_a    out  1      0 = PC, 1 = register A
//  alu_src_b    out  2      00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  alu_op       out  2      00 add, 01 sub, 10 funct-decoded
//  pc_source    out  2      00 ALU, 01 ALUOut, 10 jump target
//  retire       out  1      one-cycle pulse when an instruction completes
//  illegal      out  1      sticky: trap entered
//  cycle_cnt    out  CNT_W  cycles since reset (0 without MC_PERF_CNT_EN)
//  instr_cnt    out  CNT_W  retired instructions (0 without MC_PERF_CNT_EN)
// BEHAVIOUR
//  - States: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC,
//    7 RTYPE_WB, 8 BEQ, 9 JUMP, 15 TRAP.
//  - Reset (async): cur_state=FETCH, run=0, illegal=0, counters 0. While run=0
//    every control output is 0 and retire=0. run is set at the first clock edge
//    after rst is released; that edge does not advance the state.
//  - With run=1 cur_state <= next_state every clock, except for these cases:
//    - Stall: in FETCH, MEMRD or MEMWR with mem_ready=0, the state holds.
//      mem_read/mem_write stay asserted. pc_write, ir_write and reg_write are 0.
//    - In DECODE with opcode not in {0,2,4,35,43}, go to TRAP.
//    - If next_state is in 10..14, go to TRAP.
//    - TRAP: all controls 0, illegal=1, held until rst.
//  - Decode (unlisted outputs are 0):
//    - FETCH: mem_read, alu_src_b=01, alu_op=00, pc_source=00.
//      ir_write and pc_write are asserted only when mem_ready=1.
//    - DECODE: alu_src_b=11, alu_op=00.
//    - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00.
//    - MEMRD: mem_read, i_or_d=1.
//    - MEMWB: reg_write, mem_to_reg=1.
//    - MEMWR: mem_write, i_or_d=1.
//    - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
//    - RTYPE_WB: reg_write, reg_dst=1.
//    - BEQ: alu_src_a=1, alu_op=01, pc_write_cond, pc_source=01.
//    - JUMP: pc_write, pc_source=10.
//  - retire=1 (combinational) during the last cycle of an instruction:
//    MEMWB, RTYPE_WB, BEQ, JUMP, or MEMWR with mem_ready=1.
//  - Latency, no stalls: lw 5, sw 4, R-type 4, beq 3, j 3 cycles.
//  - Reset asserted mid-instruction: controls drop to 0 immediately,
//    asynchronously; the partial instruction is never retired.
// CONFIGURATION
//  MC_PERF_CNT_EN defined:
//    - cycle_cnt increments every run=1 cycle outside TRAP.
//    - instr_cnt increments on retire.
//    - Both wrap modulo 2^CNT_W.
//  MC_PERF_CNT_EN undefined: no counter flops; cycle_cnt and instr_cnt tied to 0.
// STRUCTURE
//  Package mc_ctrl_pkg holds the state encodings, opcode constants
//  (RTYPE=0, J=2, BEQ=4, LW=35, SW=43), and the alu_op, alu_src_b and
//  pc_source codes.
//  Sub-module mc_ctrl_outdec: purely combinational decode of
//  (cur_state, mem_ready, run) to the control word.
// TESTING
//  1. Release rst, then lw (op 35) with mem_ready=1 ->
//     states 0,1,2,3,4; retire pulses at MEMWB only; instr_cnt=1.
//  2. sw with mem_ready low for 3 cycles in MEMWR ->
//     state 5 held 3 cycles with mem_write=1; retire on the 4th cycle.
//  3. FETCH with mem_ready=0 for 2 cycles ->
//     ir_write and pc_write stay 0 until mem_ready=1, then a single pulse.
//  4. opcode=6'd8 in DECODE -> TRAP; illegal=1 and all controls 0
//     until rst; counters frozen.
//  5. beq then j back-to-back -> states 0,1,8,0,1,9;
//     pc_write_cond=1 in 8; pc_write=1 with pc_source=10 in 9.
//  6. rst asserted during EXEC -> cur_state=0 and all controls 0 in the same
//     cycle; no retire is issued.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state encodings, opcodes and control-field codes for the multi-cycle sequencer
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMRD    = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWR    = 4'd5,
    ST_EXEC     = 4'd6,
    ST_RTYPE_WB = 4'd7,
    ST_BEQ      = 4'd8,
    ST_JUMP     = 4'd9,
    ST_TRAP     = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_source_e pc_source;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - combinational decode of (state, mem_ready, run) into the datapath control word
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e cur_state,
  input  logic   mem_ready,
  input  logic   run,
  output ctrl_t  ctrl,
  output logic   retire
);

  // Control word per state; everything defaults to 0 so idle, TRAP and
  // unused encodings are quiet. Stalled states keep their memory request
  // but suppress the architectural writes gated by mem_ready.
  always_comb begin
    ctrl   = '0;
    retire = 1'b0;
    if (run) begin
      case (cur_state)
        ST_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALU_ADD;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        ST_DECODE: begin
          ctrl.alu_src_b = SRCB_IMM_SH;
          ctrl.alu_op    = ALU_ADD;
        end
        ST_MEMADR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALU_ADD;
        end
        ST_MEMRD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        ST_MEMWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          retire          = 1'b1;
        end
        ST_MEMWR: begin
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
          retire         = mem_ready;
        end
        ST_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_B;
          ctrl.alu_op    = ALU_FUNCT;
        end
        ST_RTYPE_WB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
          retire         = 1'b1;
        end
        ST_BEQ: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_op        = ALU_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
          retire             = 1'b1;
        end
        ST_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
          retire         = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl_sequencer.sv
// rtl/mc_ctrl_sequencer.sv - state register, stall/trap handling and control outputs; MC_PERF_CNT_EN adds cycle/instruction counters
module mc_ctrl_sequencer
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       next_state,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic [3:0]       cur_state,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e state_q, state_d;
  logic   run_q, run_d;
  logic   illegal_q, illegal_d;
  logic   stall;
  ctrl_t  ctrl;
  logic   retire_w;

  // Memory-facing states wait for mem_ready before moving on.
  assign stall = ((state_q == ST_FETCH) || (state_q == ST_MEMRD) ||
                  (state_q == ST_MEMWR)) && !mem_ready;

  // Next state: the first edge after reset only arms run; TRAP is absorbing;
  // bad opcodes and unused proposals 10..14 divert to TRAP.
  always_comb begin
    state_d   = state_q;
    run_d     = 1'b1;
    illegal_d = illegal_q;
    if (run_q) begin
      if (state_q == ST_TRAP) begin
        state_d = ST_TRAP;
      end else if (stall) begin
        state_d = state_q;
      end else if ((state_q == ST_DECODE) && !op_legal(opcode)) begin
        state_d = ST_TRAP;
      end else if ((next_state >= 4'd10) && (next_state <= 4'd14)) begin
        state_d = ST_TRAP;
      end else begin
        state_d = state_e'(next_state);
      end
    end
    if (state_d == ST_TRAP) begin
      illegal_d = 1'b1;
    end
  end

  // State, run and sticky trap flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      run_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      illegal_q <= illegal_d;
    end
  end

  mc_ctrl_outdec u_outdec (
    .cur_state (state_q),
    .mem_ready (mem_ready),
    .run       (run_q),
    .ctrl      (ctrl),
    .retire    (retire_w)
  );

  assign cur_state     = state_q;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign retire        = retire_w;
  assign illegal       = illegal_q;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;

  // Counters freeze in TRAP and while idle after reset; both wrap naturally.
  always_comb begin
    cyc_d = cyc_q;
    ins_d = ins_q;
    if (run_q && (state_q != ST_TRAP)) begin
      cyc_d = cyc_q + CNT_W'(1);
    end
    if (retire_w) begin
      ins_d = ins_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_sequencer.sv
// tb/tb_mc_ctrl_sequencer.sv - randomized scoreboard bench for mc_ctrl_sequencer
module tb_mc_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  next_state = '0;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic [3:0]  cur_state;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic        retire, illegal;
  logic [31:0] cycle_cnt, instr_cnt;

  mc_ctrl_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .next_state(next_state), .opcode(opcode),
    .mem_ready(mem_ready), .cur_state(cur_state), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .retire(retire), .illegal(illegal), .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ret;
    logic        ill;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_cyc = '0;
  logic [31:0] m_ins = '0;

  // Expected control word {pw,pwc,iod,mrd,mwr,irw,rdst,m2r,rw,asa,asb,aop,psrc}.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
    logic pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0: begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1: asb = 2'b11;
      4'd2: begin asa = 1; asb = 2'b10; end
      4'd3: begin mrd = 1; iod = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mwr = 1; iod = 1; end
      4'd6: begin asa = 1; aop = 2'b10; end
      4'd7: begin rw = 1; rdst = 1; end
      4'd8: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      4'd9: begin pw = 1; psrc = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, psrc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("cur_state", {28'd0, cur_state}, {28'd0, e.st});
      chk("ctrl_word", {16'd0, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                        ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                        alu_src_b, alu_op, pc_source}, {16'd0, e.ctrl});
      chk("retire", {31'd0, retire}, {31'd0, e.ret});
      chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
      chk("cycle_cnt", cycle_cnt, e.cyc);
      chk("instr_cnt", instr_cnt, e.ins);
    end
  end

  // Drive one cycle of inputs and push what the sequencer should show for it.
  task automatic step(input logic [3:0] st, input logic mr, input logic [3:0] ns,
                      input logic [5:0] op, input logic r);
    exp_t e;
    logic ret;
    mem_ready  = mr;
    next_state = ns;
    opcode     = op;
    ret = r && (st == 4 || st == 7 || st == 8 || st == 9 || (st == 5 && mr));
    e.st   = st;
    e.ctrl = r ? exp_ctrl(st, mr) : 16'd0;
    e.ret  = ret;
    e.ill  = (st == 4'd15);
`ifdef MC_PERF_CNT_EN
    e.cyc = m_cyc;
    e.ins = m_ins;
`else
    e.cyc = '0;
    e.ins = '0;
`endif
    sb.push_back(e);
    if (r && st != 4'd15) m_cyc++;
    if (ret) m_ins++;
    @(posedge clk); #1;
  endtask

  task automatic zero_cycle();
    exp_t e;
    e = '0;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_cyc = '0;
    m_ins = '0;
    zero_cycle();
    zero_cycle();
    rst = 1'b0;
    step(4'd0, 1'($urandom), 4'($urandom), 6'($urandom), 1'b0);
  endtask

  task automatic trap_for(input int n);
    repeat (n) step(4'd15, 1'($urandom), 4'($urandom), 6'($urandom), 1'b1);
  endtask

  // kind: 0 lw, 1 sw, 2 R-type, 3 beq, 4 j; negative stall counts are random.
  task automatic run_instr(input int kind, input int fstall, input int mstall, input bit bad_ns);
    int seq[$];
    logic [5:0] op;
    case (kind)
      0: begin seq = '{0, 1, 2, 3, 4}; op = 6'd35; end
      1: begin seq = '{0, 1, 2, 5};    op = 6'd43; end
      2: begin seq = '{0, 1, 6, 7};    op = 6'd0;  end
      3: begin seq = '{0, 1, 8};       op = 6'd4;  end
      default: begin seq = '{0, 1, 9}; op = 6'd2;  end
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      logic [3:0] st, ns;
      int n;
      st = 4'(seq[i]);
      ns = (i == seq.size() - 1) ? 4'd0 : 4'(seq[i+1]);
      if (bad_ns && st == 4'd6) begin
        step(st, 1'($urandom), 4'(10 + $urandom_range(0, 4)), op, 1'b1);
        trap_for(3);
        return;
      end
      if (st == 0 || st == 3 || st == 5) begin
        n = (st == 0) ? fstall : mstall;
        if (n < 0) n = $urandom_range(0, 2);
        repeat (n) step(st, 1'b0, ns, op, 1'b1);
        step(st, 1'b1, ns, op, 1'b1);
      end else begin
        step(st, 1'($urandom), ns, op, 1'b1);
      end
    end
  endtask

  task automatic run_illegal(input logic [5:0] op);
    step(4'd0, 1'b1, 4'd1, op, 1'b1);
    step(4'd1, 1'($urandom), 4'd2, op, 1'b1);
    trap_for(4);
  endtask

  task automatic reset_in_exec();
    step(4'd0, 1'b1, 4'd1, 6'd0, 1'b1);
    step(4'd1, 1'b0, 4'd6, 6'd0, 1'b1);
    do_reset();
  endtask

  function automatic logic [5:0] rand_bad_op();
    logic [5:0] op;
    do op = 6'($urandom);
    while (op == 0 || op == 2 || op == 4 || op == 35 || op == 43);
    return op;
  endfunction

  initial begin
    @(posedge clk); #1;
    do_reset();
    run_instr(0, 0, 0, 1'b0);
    run_instr(1, 0, 3, 1'b0);
    run_instr(2, 2, 0, 1'b0);
    run_instr(3, 0, 0, 1'b0);
    run_instr(4, 0, 0, 1'b0);
    run_illegal(6'd8);
    do_reset();
    reset_in_exec();
    run_instr(2, 0, 0, 1'b1);
    do_reset();
    for (int k = 0; k < 80; k++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 15) run_instr(r % 5, -1, -1, 1'b0);
      else if (r == 15) begin run_illegal(rand_bad_op()); do_reset(); end
      else if (r == 16) begin run_instr(2, -1, -1, 1'b1); do_reset(); end
      else if (r == 17) reset_in_exec();
      else do_reset();
    end
    @(negedge clk); #1;
    chk("scoreboard_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
